core_mem_ctrl_ws: RTL and testbench

- Parametrised, sequential successor of the core memory controller.
- Serves a program-fetch channel and a data channel (byte/bit read/write) through a registered FSM.
- Routes each access to the internal ROM/RAM macro ports or to the external bus, with programmable external wait states.
- Adds behaviour the combinational controller lacks: level req/ack handshakes, arbitration with alternation, and read-modify-write bit writes.

---
 rtl/core_mem_ctrl_pkg.sv | 21 ++
 rtl/core_mem_ctrl_bit_alu.sv | 26 ++
 rtl/core_mem_ctrl_ws.sv | 219 +++++++++++++++++++++
 tb/tb_core_mem_ctrl_ws.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core_mem_ctrl_pkg.sv
// Shared types and constants for the wait-state core memory controller.
package core_mem_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INT_ACC,
      ST_BIT_RD,
      ST_BIT_WR,
      ST_EXT_STB,
      ST_DONE
   } state_t;

   typedef enum logic {
      CH_FETCH,
      CH_DATA
   } chan_t;

   localparam logic STB_OFF = 1'b1;
   localparam int unsigned BIT_BASE_DEF = 'h20;

endpackage

// File: rtl/core_mem_ctrl_bit_alu.sv
// Bit-area helper: byte address of a bit, bit extract and bit insert for RMW.
module core_mem_ctrl_bit_alu
   import core_mem_ctrl_pkg::*;
#(
   parameter int unsigned RAM_AW   = 7,
   parameter int unsigned DW       = 8,
   parameter int unsigned BIT_BASE = BIT_BASE_DEF
) (
   input  logic [6:0]        bit_addr,
   input  logic [DW-1:0]     byte_in,
   input  logic              bit_val,
   output logic [RAM_AW-1:0] byte_addr,
   output logic              bit_out,
   output logic [DW-1:0]     byte_out
);

   // Truncation to RAM_AW wraps the bit area inside the RAM.
   assign byte_addr = RAM_AW'(BIT_BASE + 32'(bit_addr[6:3]));
   assign bit_out   = byte_in[bit_addr[2:0]];

   always_comb begin
      byte_out                = byte_in;
      byte_out[bit_addr[2:0]] = bit_val;
   end

endmodule

// File: rtl/core_mem_ctrl_ws.sv
// Sequential memory controller: fetch and data channels routed to internal
// ROM/RAM or the external bus, with external wait states and bit RMW.
module core_mem_ctrl_ws
   import core_mem_ctrl_pkg::*;
#(
   parameter int unsigned ROM_AW   = 12,
   parameter int unsigned RAM_AW   = 7,
   parameter int unsigned EXT_AW   = 16,
   parameter int unsigned DW       = 8,
   parameter int unsigned EXT_WAIT = 2,
   parameter int unsigned BIT_BASE = BIT_BASE_DEF
) (
   input  logic              mem_ctrl_clk_i,
   input  logic              mem_ctrl_rst_i,
   input  logic              mem_ctrl_fetch_req_i,
   input  logic [EXT_AW-1:0] mem_ctrl_fetch_addr_i,
   output logic              mem_ctrl_fetch_ack_o,
   output logic [DW-1:0]     mem_ctrl_fetch_data_o,
   input  logic              mem_ctrl_data_req_i,
   input  logic              mem_ctrl_data_we_i,
   input  logic              mem_ctrl_data_bit_i,
   input  logic              mem_ctrl_data_ext_i,
   input  logic [7:0]        mem_ctrl_data_addr_i,
   input  logic [DW-1:0]     mem_ctrl_data_wdata_i,
   output logic              mem_ctrl_data_ack_o,
   output logic [DW-1:0]     mem_ctrl_data_rdata_o,
   input  logic              mem_ctrl_bus_ctrl_ea_b_i,
   output logic [EXT_AW-1:0] mem_ctrl_bus_ctrl_addr_o,
   output logic [DW-1:0]     mem_ctrl_bus_ctrl_data_o,
   input  logic [DW-1:0]     mem_ctrl_bus_ctrl_data_i,
   output logic              mem_ctrl_bus_ctrl_ext_rom_rd_b_o,
   output logic              mem_ctrl_bus_ctrl_ext_ram_rd_b_o,
   output logic              mem_ctrl_bus_ctrl_ext_ram_wr_b_o,
   output logic              mem_ctrl_int_rom_en_b_o,
   output logic              mem_ctrl_int_rom_rd_b_o,
   output logic [ROM_AW-1:0] mem_ctrl_int_rom_addr_o,
   input  logic [DW-1:0]     mem_ctrl_int_rom_data_i,
   output logic              mem_ctrl_int_ram_en_b_o,
   output logic              mem_ctrl_int_ram_rd_b_o,
   output logic              mem_ctrl_int_ram_wr_b_o,
   output logic [RAM_AW-1:0] mem_ctrl_int_ram_addr_o,
   output logic [DW-1:0]     mem_ctrl_int_ram_data_o,
   input  logic [DW-1:0]     mem_ctrl_int_ram_data_i
);

   state_t      state;
   chan_t       cur_ch;
   chan_t       last_ch;
   logic        lat_we;
   logic        lat_wbit;
   logic [6:0]  lat_daddr;
   logic [3:0]  wait_cnt;

   logic              grant_data;
   logic              grant_fetch;
   logic              fetch_ext;
   logic [6:0]        alu_addr;
   logic [RAM_AW-1:0] alu_byte_addr;
   logic              alu_bit;
   logic [DW-1:0]     alu_byte;

   // Data wins unless it was granted last time and fetch is waiting.
   assign grant_data  = mem_ctrl_data_req_i && !(last_ch == CH_DATA && mem_ctrl_fetch_req_i);
   assign grant_fetch = mem_ctrl_fetch_req_i && !grant_data;
   assign fetch_ext   = !mem_ctrl_bus_ctrl_ea_b_i || ((mem_ctrl_fetch_addr_i >> ROM_AW) != '0);
   assign alu_addr    = (state == ST_IDLE) ? mem_ctrl_data_addr_i[6:0] : lat_daddr;

   core_mem_ctrl_bit_alu #(
      .RAM_AW   (RAM_AW),
      .DW       (DW),
      .BIT_BASE (BIT_BASE)
   ) u_bit_alu (
      .bit_addr  (alu_addr),
      .byte_in   (mem_ctrl_int_ram_data_i),
      .bit_val   (lat_wbit),
      .byte_addr (alu_byte_addr),
      .bit_out   (alu_bit),
      .byte_out  (alu_byte)
   );

   always_ff @(posedge mem_ctrl_clk_i) begin
      if (mem_ctrl_rst_i) begin
         state                            <= ST_IDLE;
         cur_ch                           <= CH_FETCH;
         last_ch                          <= CH_FETCH;
         lat_we                           <= 1'b0;
         lat_wbit                         <= 1'b0;
         lat_daddr                        <= '0;
         wait_cnt                         <= '0;
         mem_ctrl_fetch_ack_o             <= 1'b0;
         mem_ctrl_fetch_data_o            <= '0;
         mem_ctrl_data_ack_o              <= 1'b0;
         mem_ctrl_data_rdata_o            <= '0;
         mem_ctrl_bus_ctrl_addr_o         <= '0;
         mem_ctrl_bus_ctrl_data_o         <= '0;
         mem_ctrl_bus_ctrl_ext_rom_rd_b_o <= STB_OFF;
         mem_ctrl_bus_ctrl_ext_ram_rd_b_o <= STB_OFF;
         mem_ctrl_bus_ctrl_ext_ram_wr_b_o <= STB_OFF;
         mem_ctrl_int_rom_en_b_o          <= STB_OFF;
         mem_ctrl_int_rom_rd_b_o          <= STB_OFF;
         mem_ctrl_int_rom_addr_o          <= '0;
         mem_ctrl_int_ram_en_b_o          <= STB_OFF;
         mem_ctrl_int_ram_rd_b_o          <= STB_OFF;
         mem_ctrl_int_ram_wr_b_o          <= STB_OFF;
         mem_ctrl_int_ram_addr_o          <= '0;
         mem_ctrl_int_ram_data_o          <= '0;
      end else begin
         mem_ctrl_fetch_ack_o <= 1'b0;
         mem_ctrl_data_ack_o  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (grant_fetch) begin
                  cur_ch  <= CH_FETCH;
                  last_ch <= CH_FETCH;
                  if (fetch_ext) begin
                     mem_ctrl_bus_ctrl_addr_o         <= mem_ctrl_fetch_addr_i;
                     mem_ctrl_bus_ctrl_ext_rom_rd_b_o <= 1'b0;
                     wait_cnt                         <= 4'(EXT_WAIT);
                     state                            <= ST_EXT_STB;
                  end else begin
                     mem_ctrl_int_rom_addr_o <= mem_ctrl_fetch_addr_i[ROM_AW-1:0];
                     mem_ctrl_int_rom_en_b_o <= 1'b0;
                     mem_ctrl_int_rom_rd_b_o <= 1'b0;
                     state                   <= ST_INT_ACC;
                  end
               end else if (grant_data) begin
                  cur_ch    <= CH_DATA;
                  last_ch   <= CH_DATA;
                  lat_we    <= mem_ctrl_data_we_i;
                  lat_wbit  <= mem_ctrl_data_wdata_i[0];
                  lat_daddr <= mem_ctrl_data_addr_i[6:0];
                  if (mem_ctrl_data_ext_i) begin
                     mem_ctrl_bus_ctrl_addr_o <= EXT_AW'(mem_ctrl_data_addr_i);
                     if (mem_ctrl_data_we_i) begin
                        mem_ctrl_bus_ctrl_data_o         <= mem_ctrl_data_wdata_i;
                        mem_ctrl_bus_ctrl_ext_ram_wr_b_o <= 1'b0;
                     end else begin
                        mem_ctrl_bus_ctrl_ext_ram_rd_b_o <= 1'b0;
                     end
                     wait_cnt <= 4'(EXT_WAIT);
                     state    <= ST_EXT_STB;
                  end else if (mem_ctrl_data_bit_i) begin
                     mem_ctrl_int_ram_addr_o <= alu_byte_addr;
                     mem_ctrl_int_ram_en_b_o <= 1'b0;
                     mem_ctrl_int_ram_rd_b_o <= 1'b0;
                     state                   <= ST_BIT_RD;
                  end else begin
                     mem_ctrl_int_ram_addr_o <= RAM_AW'(mem_ctrl_data_addr_i);
                     mem_ctrl_int_ram_en_b_o <= 1'b0;
                     if (mem_ctrl_data_we_i) begin
                        mem_ctrl_int_ram_data_o <= mem_ctrl_data_wdata_i;
                        mem_ctrl_int_ram_wr_b_o <= 1'b0;
                     end else begin
                        mem_ctrl_int_ram_rd_b_o <= 1'b0;
                     end
                     state <= ST_INT_ACC;
                  end
               end
            end
            ST_INT_ACC: begin
               mem_ctrl_int_rom_en_b_o <= STB_OFF;
               mem_ctrl_int_rom_rd_b_o <= STB_OFF;
               mem_ctrl_int_ram_en_b_o <= STB_OFF;
               mem_ctrl_int_ram_rd_b_o <= STB_OFF;
               mem_ctrl_int_ram_wr_b_o <= STB_OFF;
               if (cur_ch == CH_FETCH) begin
                  mem_ctrl_fetch_data_o <= mem_ctrl_int_rom_data_i;
                  mem_ctrl_fetch_ack_o  <= 1'b1;
               end else begin
                  if (!lat_we) mem_ctrl_data_rdata_o <= mem_ctrl_int_ram_data_i;
                  mem_ctrl_data_ack_o <= 1'b1;
               end
               state <= ST_DONE;
            end
            ST_BIT_RD: begin
               // Bit writes turn the read cycle straight into the write-back cycle.
               if (lat_we) begin
                  mem_ctrl_int_ram_rd_b_o <= STB_OFF;
                  mem_ctrl_int_ram_wr_b_o <= 1'b0;
                  mem_ctrl_int_ram_data_o <= alu_byte;
                  state                   <= ST_BIT_WR;
               end else begin
                  mem_ctrl_int_ram_en_b_o <= STB_OFF;
                  mem_ctrl_int_ram_rd_b_o <= STB_OFF;
                  mem_ctrl_data_rdata_o   <= DW'(alu_bit);
                  mem_ctrl_data_ack_o     <= 1'b1;
                  state                   <= ST_DONE;
               end
            end
            ST_BIT_WR: begin
               mem_ctrl_int_ram_en_b_o <= STB_OFF;
               mem_ctrl_int_ram_wr_b_o <= STB_OFF;
               mem_ctrl_data_ack_o     <= 1'b1;
               state                   <= ST_DONE;
            end
            ST_EXT_STB: begin
               if (wait_cnt == '0) begin
                  mem_ctrl_bus_ctrl_ext_rom_rd_b_o <= STB_OFF;
                  mem_ctrl_bus_ctrl_ext_ram_rd_b_o <= STB_OFF;
                  mem_ctrl_bus_ctrl_ext_ram_wr_b_o <= STB_OFF;
                  if (cur_ch == CH_FETCH) begin
                     mem_ctrl_fetch_data_o <= mem_ctrl_bus_ctrl_data_i;
                     mem_ctrl_fetch_ack_o  <= 1'b1;
                  end else begin
                     if (!lat_we) mem_ctrl_data_rdata_o <= mem_ctrl_bus_ctrl_data_i;
                     mem_ctrl_data_ack_o <= 1'b1;
                  end
                  state <= ST_DONE;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_core_mem_ctrl_ws.sv
// Bench for core_mem_ctrl_ws: vector table with scoreboard plus corner sequences.
module tb_core_mem_ctrl_ws;

   localparam int unsigned EW = 2;

   typedef struct {
      logic        is_data;
      logic        we;
      logic        bitacc;
      logic        ext;
      logic        ea_b;
      logic [15:0] addr;
      logic [7:0]  wdata;
      logic [7:0]  exp_data;
      int unsigned exp_lat;
      int unsigned exp_ext;
      logic [15:0] exp_bus;
      logic        chk_mem;
      logic [6:0]  mem_addr;
      logic [7:0]  mem_val;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        fetch_req, fetch_ack, data_req, data_we, data_bit, data_ext, data_ack, ea_b;
   logic [15:0] fetch_addr, bus_addr;
   logic [7:0]  fetch_data, data_addr, data_wdata, data_rdata, bus_wdata, bus_rdata;
   logic        ext_rom_rd_b, ext_ram_rd_b, ext_ram_wr_b;
   logic        rom_en_b, rom_rd_b, ram_en_b, ram_rd_b, ram_wr_b;
   logic [11:0] rom_addr;
   logic [6:0]  ram_addr;
   logic [7:0]  rom_q, ram_d, ram_q;

   logic        fetch_ack2, data_ack2, ext_rom_rd_b2, ext_ram_rd_b2, ext_ram_wr_b2;
   logic        rom_en_b2, rom_rd_b2, ram_en_b2, ram_rd_b2, ram_wr_b2;
   logic [7:0]  fetch_data2, data_rdata2, bus_wdata2, ram_d2;
   logic [15:0] bus_addr2;
   logic [11:0] rom_addr2;
   logic [6:0]  ram_addr2;

   logic [7:0]  mem [0:127];

   assign rom_q     = rom_addr[7:0] + {4'h0, rom_addr[11:8]} + 8'h81;
   assign ram_q     = mem[ram_addr];
   assign bus_rdata = bus_addr[7:0] ^ 8'h3C;

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 128; i++) mem[i] <= (i == 'h21) ? 8'h00 : 8'(i) ^ 8'h55;
      end else if (!ram_en_b && !ram_wr_b) begin
         mem[ram_addr] <= ram_d;
      end
   end

   core_mem_ctrl_ws #(.EXT_WAIT(EW)) dut (
      .mem_ctrl_clk_i(clk), .mem_ctrl_rst_i(rst),
      .mem_ctrl_fetch_req_i(fetch_req), .mem_ctrl_fetch_addr_i(fetch_addr),
      .mem_ctrl_fetch_ack_o(fetch_ack), .mem_ctrl_fetch_data_o(fetch_data),
      .mem_ctrl_data_req_i(data_req), .mem_ctrl_data_we_i(data_we), .mem_ctrl_data_bit_i(data_bit),
      .mem_ctrl_data_ext_i(data_ext), .mem_ctrl_data_addr_i(data_addr), .mem_ctrl_data_wdata_i(data_wdata),
      .mem_ctrl_data_ack_o(data_ack), .mem_ctrl_data_rdata_o(data_rdata),
      .mem_ctrl_bus_ctrl_ea_b_i(ea_b), .mem_ctrl_bus_ctrl_addr_o(bus_addr),
      .mem_ctrl_bus_ctrl_data_o(bus_wdata), .mem_ctrl_bus_ctrl_data_i(bus_rdata),
      .mem_ctrl_bus_ctrl_ext_rom_rd_b_o(ext_rom_rd_b), .mem_ctrl_bus_ctrl_ext_ram_rd_b_o(ext_ram_rd_b),
      .mem_ctrl_bus_ctrl_ext_ram_wr_b_o(ext_ram_wr_b),
      .mem_ctrl_int_rom_en_b_o(rom_en_b), .mem_ctrl_int_rom_rd_b_o(rom_rd_b),
      .mem_ctrl_int_rom_addr_o(rom_addr), .mem_ctrl_int_rom_data_i(rom_q),
      .mem_ctrl_int_ram_en_b_o(ram_en_b), .mem_ctrl_int_ram_rd_b_o(ram_rd_b), .mem_ctrl_int_ram_wr_b_o(ram_wr_b),
      .mem_ctrl_int_ram_addr_o(ram_addr), .mem_ctrl_int_ram_data_o(ram_d), .mem_ctrl_int_ram_data_i(ram_q)
   );

   // Zero-wait-state instance sharing the same stimulus.
   core_mem_ctrl_ws #(.EXT_WAIT(0)) dut0 (
      .mem_ctrl_clk_i(clk), .mem_ctrl_rst_i(rst),
      .mem_ctrl_fetch_req_i(fetch_req), .mem_ctrl_fetch_addr_i(fetch_addr),
      .mem_ctrl_fetch_ack_o(fetch_ack2), .mem_ctrl_fetch_data_o(fetch_data2),
      .mem_ctrl_data_req_i(data_req), .mem_ctrl_data_we_i(data_we), .mem_ctrl_data_bit_i(data_bit),
      .mem_ctrl_data_ext_i(data_ext), .mem_ctrl_data_addr_i(data_addr), .mem_ctrl_data_wdata_i(data_wdata),
      .mem_ctrl_data_ack_o(data_ack2), .mem_ctrl_data_rdata_o(data_rdata2),
      .mem_ctrl_bus_ctrl_ea_b_i(ea_b), .mem_ctrl_bus_ctrl_addr_o(bus_addr2),
      .mem_ctrl_bus_ctrl_data_o(bus_wdata2), .mem_ctrl_bus_ctrl_data_i(bus_rdata),
      .mem_ctrl_bus_ctrl_ext_rom_rd_b_o(ext_rom_rd_b2), .mem_ctrl_bus_ctrl_ext_ram_rd_b_o(ext_ram_rd_b2),
      .mem_ctrl_bus_ctrl_ext_ram_wr_b_o(ext_ram_wr_b2),
      .mem_ctrl_int_rom_en_b_o(rom_en_b2), .mem_ctrl_int_rom_rd_b_o(rom_rd_b2),
      .mem_ctrl_int_rom_addr_o(rom_addr2), .mem_ctrl_int_rom_data_i(rom_q),
      .mem_ctrl_int_ram_en_b_o(ram_en_b2), .mem_ctrl_int_ram_rd_b_o(ram_rd_b2), .mem_ctrl_int_ram_wr_b_o(ram_wr_b2),
      .mem_ctrl_int_ram_addr_o(ram_addr2), .mem_ctrl_int_ram_data_o(ram_d2), .mem_ctrl_int_ram_data_i(ram_q)
   );

   int unsigned checks = 0;
   int unsigned errors = 0;
   vec_t        vecs [17];
   vec_t        sb_q [$];
   logic        ord_q [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1; fetch_req = 1'b0; data_req = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      int unsigned n, ext_cyc;
      logic        got;
      logic [15:0] cap_addr;
      logic [7:0]  cap_data;
      vec_t        e;
      @(posedge clk); #1;
      ea_b = v.ea_b;
      if (v.is_data) begin
         data_we = v.we; data_bit = v.bitacc; data_ext = v.ext;
         data_addr = v.addr[7:0]; data_wdata = v.wdata; data_req = 1'b1;
      end else begin
         fetch_addr = v.addr; fetch_req = 1'b1;
      end
      sb_q.push_back(v);
      n = 0; ext_cyc = 0; got = 1'b0; cap_addr = '0; cap_data = '0;
      while (!got && n < 20) begin
         @(posedge clk); n++;
         @(negedge clk);
         if (!ext_rom_rd_b || !ext_ram_rd_b || !ext_ram_wr_b) begin
            ext_cyc++; cap_addr = bus_addr; cap_data = bus_wdata;
         end
         if (fetch_ack || data_ack) got = 1'b1;
      end
      fetch_req = 1'b0; data_req = 1'b0;
      e = sb_q.pop_front();
      chk("ack_seen", 32'(got), 32'd1);
      if (got) begin
         chk("ack_chan", {30'd0, fetch_ack, data_ack}, e.is_data ? 32'd1 : 32'd2);
         chk("latency", n, e.exp_lat);
         if (!e.we) chk("rdata", 32'(e.is_data ? data_rdata : fetch_data), 32'(e.exp_data));
         chk("ext_strobe_cycles", ext_cyc, e.exp_ext);
         chk("strobes_off_at_ack", {29'd0, ext_rom_rd_b, ext_ram_rd_b, ext_ram_wr_b}, 32'd7);
         if (e.exp_ext != 0) begin
            chk("bus_addr", 32'(cap_addr), 32'(e.exp_bus));
            if (e.we) chk("bus_wdata", 32'(cap_data), 32'(e.wdata));
         end
         @(negedge clk);
         chk("ack_one_cycle", {30'd0, fetch_ack, data_ack}, 32'd0);
         if (e.chk_mem) chk("ram_contents", 32'(mem[e.mem_addr]), 32'(e.mem_val));
      end
   endtask

   initial begin
      int unsigned n, cyc, acks;
      logic        got, exp_ch;
      logic [15:0] ca;
      logic [7:0]  cd;

      vecs[0]  = '{0,0,0,0,1,16'h0123,8'h00,8'hA5,2,0,16'h0000,0,7'h00,8'h00};
      vecs[1]  = '{0,0,0,0,1,16'h1000,8'h00,8'h3C,EW+2,EW+1,16'h1000,0,7'h00,8'h00};
      vecs[2]  = '{0,0,0,0,0,16'h0010,8'h00,8'h2C,EW+2,EW+1,16'h0010,0,7'h00,8'h00};
      vecs[3]  = '{1,1,1,0,1,16'h000B,8'h01,8'h00,3,0,16'h0000,1,7'h21,8'h08};
      vecs[4]  = '{1,0,1,0,1,16'h000B,8'h00,8'h01,2,0,16'h0000,0,7'h00,8'h00};
      vecs[5]  = '{1,0,1,0,1,16'h000A,8'h00,8'h00,2,0,16'h0000,0,7'h00,8'h00};
      vecs[6]  = '{1,0,0,0,1,16'h0021,8'h00,8'h08,2,0,16'h0000,0,7'h00,8'h00};
      vecs[7]  = '{1,1,0,0,1,16'h0030,8'hC3,8'h00,2,0,16'h0000,1,7'h30,8'hC3};
      vecs[8]  = '{1,0,0,0,1,16'h0030,8'h00,8'hC3,2,0,16'h0000,0,7'h00,8'h00};
      vecs[9]  = '{1,0,0,1,1,16'h0040,8'h00,8'h7C,EW+2,EW+1,16'h0040,0,7'h00,8'h00};
      vecs[10] = '{1,1,1,1,1,16'h0040,8'h5A,8'h00,EW+2,EW+1,16'h0040,0,7'h00,8'h00};
      vecs[11] = '{1,1,1,0,1,16'h007F,8'h01,8'h00,3,0,16'h0000,1,7'h2F,8'hFA};
      vecs[12] = '{1,1,1,0,1,16'h0079,8'hFE,8'h00,3,0,16'h0000,1,7'h2F,8'hF8};
      vecs[13] = '{1,0,1,0,1,16'h00FB,8'h00,8'h01,2,0,16'h0000,0,7'h00,8'h00};
      vecs[14] = '{1,0,0,0,1,16'h00A1,8'h00,8'h08,2,0,16'h0000,0,7'h00,8'h00};
      vecs[15] = '{0,0,0,0,1,16'h0FFF,8'h00,8'h8F,2,0,16'h0000,0,7'h00,8'h00};
      vecs[16] = '{1,0,0,0,1,16'h002F,8'h00,8'hF8,2,0,16'h0000,0,7'h00,8'h00};

      rst = 1'b1; fetch_req = 1'b0; fetch_addr = '0; data_req = 1'b0; data_we = 1'b0;
      data_bit = 1'b0; data_ext = 1'b0; data_addr = '0; data_wdata = '0; ea_b = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_strobes", {24'd0, ext_rom_rd_b, ext_ram_rd_b, ext_ram_wr_b, rom_en_b, rom_rd_b,
                          ram_en_b, ram_rd_b, ram_wr_b}, 32'hFF);
      chk("rst_acks", {30'd0, fetch_ack, data_ack}, 32'd0);
      chk("rst_addrs", {bus_addr, rom_addr, 4'd0}, 32'd0);
      chk("rst_ram_addr", 32'(ram_addr), 32'd0);
      chk("rst_data", {fetch_data, data_rdata, bus_wdata, ram_d}, 32'd0);
      #1 rst = 1'b0;

      for (int i = 0; i < 17; i++) run_vec(vecs[i]);

      // Zero-wait external RAM write on the second instance.
      do_reset();
      @(posedge clk); #1;
      data_we = 1'b1; data_bit = 1'b0; data_ext = 1'b1; data_addr = 8'h40; data_wdata = 8'h5A; data_req = 1'b1;
      n = 0; cyc = 0; got = 1'b0; ca = '0; cd = '0;
      while (!got && n < 20) begin
         @(posedge clk); n++;
         @(negedge clk);
         if (!ext_ram_wr_b2) begin cyc++; ca = bus_addr2; cd = bus_wdata2; end
         if (data_ack2) got = 1'b1;
      end
      data_req = 1'b0;
      chk("ew0_ack_seen", 32'(got), 32'd1);
      chk("ew0_latency", n, 32'd2);
      chk("ew0_wr_cycles", cyc, 32'd1);
      chk("ew0_bus_addr", 32'(ca), 32'h0040);
      chk("ew0_bus_wdata", 32'(cd), 32'h5A);
      chk("ew0_wr_off_at_ack", 32'(ext_ram_wr_b2), 32'd1);

      // Contention: both held, grants must alternate starting with data.
      do_reset();
      @(posedge clk); #1;
      ea_b = 1'b1; fetch_addr = 16'h0200; fetch_req = 1'b1;
      data_we = 1'b0; data_bit = 1'b0; data_ext = 1'b0; data_addr = 8'h05; data_req = 1'b1;
      ord_q = '{1'b1, 1'b0, 1'b1, 1'b0};
      acks = 0; n = 0;
      while (acks < 4 && n < 40) begin
         @(negedge clk); n++;
         if (fetch_ack || data_ack) begin
            exp_ch = ord_q.pop_front();
            chk("arb_order", 32'(data_ack), 32'(exp_ch));
            chk("arb_data", 32'(data_ack ? data_rdata : fetch_data), exp_ch ? 32'h50 : 32'h83);
            acks++;
            if (acks == 4) begin fetch_req = 1'b0; data_req = 1'b0; end
         end
      end
      fetch_req = 1'b0; data_req = 1'b0;
      chk("arb_acks", acks, 32'd4);

      // Reset while an external fetch is strobing.
      @(posedge clk); #1;
      ea_b = 1'b1; fetch_addr = 16'h1000; fetch_req = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("mid_strobe_low", 32'(ext_rom_rd_b), 32'd0);
      rst = 1'b1; fetch_req = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("abort_strobes", {24'd0, ext_rom_rd_b, ext_ram_rd_b, ext_ram_wr_b, rom_en_b, rom_rd_b,
                            ram_en_b, ram_rd_b, ram_wr_b}, 32'hFF);
      chk("abort_no_ack", {30'd0, fetch_ack, data_ack}, 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      cyc = 0;
      repeat (4) begin
         @(negedge clk);
         if (fetch_ack || data_ack) cyc++;
      end
      chk("abort_no_late_ack", cyc, 32'd0);
      run_vec(vecs[1]);
      run_vec(vecs[0]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
